// File: rtl/instr_fetch_stage.sv
// ---------------------------------------------------------------------------
// instr_fetch_stage
//
// Fetch stage sitting directly upstream of the stall control unit. It owns
// the program counter, issues reads to program memory and captures the
// returned words into the instruction register (IR). The top opcode field
// of IR is exported as op_dec so stall control can decode hazards early.
//
// Program memory has a fixed one-cycle read latency: the word for the
// address issued while pm_en is high shows up on pm_data in the following
// cycle. Because a stall can arrive after a word has been issued, a
// one-entry skid buffer catches that in-flight word so it is never lost.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-high reset
//   stall          hold IR, block new fetch issue
//   stall_pm       force a NOP bubble into IR
//   redirect_en    jump/branch taken this cycle
//   redirect_addr  jump/branch target word address
//   pm_addr        program-memory word address (the PC)
//   pm_en          program-memory read strobe
//   pm_data        program-memory read data, valid the cycle after pm_en
//   instr_out      IR contents
//   pc_out         address of the instruction currently held in IR
//   instr_valid    IR holds a real instruction rather than a bubble
//   op_dec         IR opcode field for stall control
//   instr_count    saturating count of delivered instructions
// ---------------------------------------------------------------------------
module instr_fetch_stage #(
  parameter int              PC_W     = 10,
  parameter int              INSTR_W  = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               stall_pm,
  input  logic               redirect_en,
  input  logic [PC_W-1:0]    redirect_addr,
  output logic [PC_W-1:0]    pm_addr,
  output logic               pm_en,
  input  logic [INSTR_W-1:0] pm_data,
  output logic [INSTR_W-1:0] instr_out,
  output logic [PC_W-1:0]    pc_out,
  output logic               instr_valid,
  output logic [5:0]         op_dec,
  output logic [15:0]        instr_count
);

  localparam logic [15:0] COUNT_MAX = 16'hFFFF;

  // Architectural and pipeline state
  logic [PC_W-1:0]    pc_q;
  logic               pend_q;
  logic [PC_W-1:0]    pend_pc_q;
  logic [INSTR_W-1:0] ir_q;
  logic [PC_W-1:0]    pc_out_q;
  logic               valid_q;
  logic [INSTR_W-1:0] skid_q;
  logic [PC_W-1:0]    skid_pc_q;
  logic               skid_valid_q;
  logic [15:0]        count_q;

  // Next-state values
  logic [PC_W-1:0]    pc_d;
  logic [INSTR_W-1:0] ir_d;
  logic [PC_W-1:0]    pc_out_d;
  logic               valid_d;
  logic [INSTR_W-1:0] skid_d;
  logic [PC_W-1:0]    skid_pc_d;
  logic               skid_valid_d;
  logic               deliver;

  // A new fetch may only issue when nothing blocks it. Holding off while the
  // skid buffer is occupied guarantees at most one word is ever in flight,
  // so a single skid entry can never overflow. A taken redirect suppresses
  // issue because the current PC is on the wrong path.
  assign pm_en   = ~reset & ~stall & ~skid_valid_q & ~redirect_en;
  assign pm_addr = pc_q;

  // PC: a redirect always wins, otherwise advance only when a fetch issues.
  // The increment wraps naturally at the PC width.
  always_comb begin
    pc_d = pc_q;
    if (redirect_en) begin
      pc_d = redirect_addr;
    end else if (pm_en) begin
      pc_d = pc_q + PC_W'(1);
    end
  end

  // IR / skid steering. The priority order matters:
  //   redirect  - flush IR and drop both the skid entry and any word in
  //               flight, since they all belong to the wrong path.
  //   stall_pm  - insert a bubble; an arriving word is parked in skid.
  //   stall     - freeze IR; an arriving word is parked in skid.
  //   skid      - drain the parked word first so program order is kept.
  //   pend      - take the word arriving from program memory.
  //   otherwise - nothing to deliver, so present a bubble.
  // pc_out is left unchanged whenever IR does not receive a real word.
  always_comb begin
    ir_d         = ir_q;
    pc_out_d     = pc_out_q;
    valid_d      = valid_q;
    skid_d       = skid_q;
    skid_pc_d    = skid_pc_q;
    skid_valid_d = skid_valid_q;
    deliver      = 1'b0;

    if (redirect_en) begin
      ir_d         = '0;
      valid_d      = 1'b0;
      skid_valid_d = 1'b0;
    end else if (stall_pm || stall) begin
      if (stall_pm) begin
        ir_d    = '0;
        valid_d = 1'b0;
      end
      if (pend_q) begin
        skid_d       = pm_data;
        skid_pc_d    = pend_pc_q;
        skid_valid_d = 1'b1;
      end
    end else if (skid_valid_q) begin
      ir_d         = skid_q;
      pc_out_d     = skid_pc_q;
      valid_d      = 1'b1;
      skid_valid_d = 1'b0;
      deliver      = 1'b1;
    end else if (pend_q) begin
      ir_d     = pm_data;
      pc_out_d = pend_pc_q;
      valid_d  = 1'b1;
      deliver  = 1'b1;
    end else begin
      ir_d    = '0;
      valid_d = 1'b0;
    end
  end

  // State registers. Everything clears immediately on reset so the first
  // fetch can issue in the first cycle after reset drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      pend_q       <= 1'b0;
      pend_pc_q    <= '0;
      ir_q         <= '0;
      pc_out_q     <= '0;
      valid_q      <= 1'b0;
      skid_q       <= '0;
      skid_pc_q    <= '0;
      skid_valid_q <= 1'b0;
      count_q      <= '0;
    end else begin
      pc_q         <= pc_d;
      pend_q       <= pm_en;
      pend_pc_q    <= pc_q;
      ir_q         <= ir_d;
      pc_out_q     <= pc_out_d;
      valid_q      <= valid_d;
      skid_q       <= skid_d;
      skid_pc_q    <= skid_pc_d;
      skid_valid_q <= skid_valid_d;
      if (deliver && (count_q != COUNT_MAX)) begin
        count_q <= count_q + 16'd1;
      end
    end
  end

  assign instr_out   = ir_q;
  assign pc_out      = pc_out_q;
  assign instr_valid = valid_q;
  assign instr_count = count_q;

  // The opcode is gated with reset so stall control sees a clean zero
  // during reset regardless of the register timing.
  assign op_dec = reset ? 6'd0 : ir_q[INSTR_W-1 -: 6];

endmodule

// File: tb/tb_instr_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_stage
//
// Directed self-checking bench for instr_fetch_stage. A behavioural program
// memory returns 32'hA000_0000 | addr one cycle after pm_en, and garbage
// otherwise. Each task drives one scenario and checks its outputs inline.
// Outputs are sampled 1-2 time units after the rising edge.
// ---------------------------------------------------------------------------
module tb_instr_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        stall_pm;
  logic        redirect_en;
  logic [9:0]  redirect_addr;
  logic [9:0]  pm_addr;
  logic        pm_en;
  logic [31:0] pm_data;
  logic [31:0] instr_out;
  logic [9:0]  pc_out;
  logic        instr_valid;
  logic [5:0]  op_dec;
  logic [15:0] instr_count;

  int checks_total;
  int checks_passed;

  instr_fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .stall_pm      (stall_pm),
    .redirect_en   (redirect_en),
    .redirect_addr (redirect_addr),
    .pm_addr       (pm_addr),
    .pm_en         (pm_en),
    .pm_data       (pm_data),
    .instr_out     (instr_out),
    .pc_out        (pc_out),
    .instr_valid   (instr_valid),
    .op_dec        (op_dec),
    .instr_count   (instr_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Program memory with one-cycle read latency.
  always @(posedge clk) begin
    pm_data <= pm_en ? (32'hA000_0000 | {22'd0, pm_addr}) : 32'hDEAD_BEEF;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks_total++; if (instr_out !== 32'h0) $display("[TB] FAIL reset_ir got %h want %h", instr_out, 32'h0); else checks_passed++;
    checks_total++; if (pc_out !== 10'h0) $display("[TB] FAIL reset_pc_out got %h want %h", pc_out, 10'h0); else checks_passed++;
    checks_total++; if (instr_valid !== 1'b0) $display("[TB] FAIL reset_valid got %b want 0", instr_valid); else checks_passed++;
    checks_total++; if (instr_count !== 16'h0) $display("[TB] FAIL reset_count got %h want 0", instr_count); else checks_passed++;
    checks_total++; if (pm_en !== 1'b0) $display("[TB] FAIL reset_pm_en got %b want 0", pm_en); else checks_passed++;
    checks_total++; if (op_dec !== 6'h0) $display("[TB] FAIL reset_op_dec got %h want 0", op_dec); else checks_passed++;
    checks_total++; if (pm_addr !== 10'h0) $display("[TB] FAIL reset_pm_addr got %h want 0", pm_addr); else checks_passed++;
    reset = 1'b0;
    #1;
    checks_total++; if (pm_en !== 1'b1) $display("[TB] FAIL release_pm_en got %b want 1", pm_en); else checks_passed++;
    checks_total++; if (pm_addr !== 10'h0) $display("[TB] FAIL release_pm_addr got %h want 0", pm_addr); else checks_passed++;
  endtask

  task automatic test_stream();
    tick();
    checks_total++; if (pm_addr !== 10'h1) $display("[TB] FAIL stream_addr1 got %h want 1", pm_addr); else checks_passed++;
    checks_total++; if (instr_valid !== 1'b0) $display("[TB] FAIL stream_first_bubble got %b want 0", instr_valid); else checks_passed++;
    tick();
    checks_total++; if (instr_out !== 32'hA000_0000) $display("[TB] FAIL stream_ir0 got %h want %h", instr_out, 32'hA000_0000); else checks_passed++;
    checks_total++; if (pc_out !== 10'h0) $display("[TB] FAIL stream_pc_out0 got %h want 0", pc_out); else checks_passed++;
    checks_total++; if (instr_valid !== 1'b1) $display("[TB] FAIL stream_valid0 got %b want 1", instr_valid); else checks_passed++;
    checks_total++; if (instr_count !== 16'd1) $display("[TB] FAIL stream_count0 got %0d want 1", instr_count); else checks_passed++;
    checks_total++; if (op_dec !== 6'h28) $display("[TB] FAIL stream_op_dec got %h want 28", op_dec); else checks_passed++;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks_total++; if (instr_out !== (32'hA000_0000 | i)) $display("[TB] FAIL stream_ir%0d got %h want %h", i, instr_out, 32'hA000_0000 | i); else checks_passed++;
      checks_total++; if (instr_count !== 16'(i + 1)) $display("[TB] FAIL stream_count%0d got %0d want %0d", i, instr_count, i + 1); else checks_passed++;
      checks_total++; if (pm_addr !== 10'(i + 2)) $display("[TB] FAIL stream_addr%0d got %h want %h", i, pm_addr, i + 2); else checks_passed++;
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    #1;
    checks_total++; if (pm_en !== 1'b0) $display("[TB] FAIL stall_pm_en got %b want 0", pm_en); else checks_passed++;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks_total++; if (instr_out !== 32'hA000_0004) $display("[TB] FAIL stall_hold_ir%0d got %h want %h", i, instr_out, 32'hA000_0004); else checks_passed++;
      checks_total++; if (pm_addr !== 10'h6) $display("[TB] FAIL stall_pc%0d got %h want 6", i, pm_addr); else checks_passed++;
      checks_total++; if (instr_count !== 16'd5) $display("[TB] FAIL stall_count%0d got %0d want 5", i, instr_count); else checks_passed++;
    end
    stall = 1'b0;
    #1;
    checks_total++; if (pm_en !== 1'b0) $display("[TB] FAIL stall_skid_blocks_issue got %b want 0", pm_en); else checks_passed++;
    tick();
    checks_total++; if (instr_out !== 32'hA000_0005) $display("[TB] FAIL stall_skid_ir got %h want %h", instr_out, 32'hA000_0005); else checks_passed++;
    checks_total++; if (pc_out !== 10'h5) $display("[TB] FAIL stall_skid_pc_out got %h want 5", pc_out); else checks_passed++;
    checks_total++; if (instr_count !== 16'd6) $display("[TB] FAIL stall_skid_count got %0d want 6", instr_count); else checks_passed++;
    #1;
    checks_total++; if (pm_en !== 1'b1) $display("[TB] FAIL stall_reissue got %b want 1", pm_en); else checks_passed++;
    tick();
    checks_total++; if (instr_valid !== 1'b0) $display("[TB] FAIL stall_refill_bubble got %b want 0", instr_valid); else checks_passed++;
    tick();
    checks_total++; if (instr_out !== 32'hA000_0006) $display("[TB] FAIL stall_next_ir got %h want %h", instr_out, 32'hA000_0006); else checks_passed++;
    checks_total++; if (instr_count !== 16'd7) $display("[TB] FAIL stall_next_count got %0d want 7", instr_count); else checks_passed++;
  endtask

  task automatic test_bubble();
    stall    = 1'b1;
    stall_pm = 1'b1;
    tick();
    checks_total++; if (instr_out !== 32'h0) $display("[TB] FAIL bubble_ir got %h want 0", instr_out); else checks_passed++;
    checks_total++; if (instr_valid !== 1'b0) $display("[TB] FAIL bubble_valid got %b want 0", instr_valid); else checks_passed++;
    checks_total++; if (op_dec !== 6'h0) $display("[TB] FAIL bubble_op_dec got %h want 0", op_dec); else checks_passed++;
    checks_total++; if (instr_count !== 16'd7) $display("[TB] FAIL bubble_count got %0d want 7", instr_count); else checks_passed++;
    stall    = 1'b0;
    stall_pm = 1'b0;
    tick();
    checks_total++; if (instr_out !== 32'hA000_0007) $display("[TB] FAIL bubble_resume_ir got %h want %h", instr_out, 32'hA000_0007); else checks_passed++;
    checks_total++; if (pc_out !== 10'h7) $display("[TB] FAIL bubble_resume_pc_out got %h want 7", pc_out); else checks_passed++;
    checks_total++; if (instr_count !== 16'd8) $display("[TB] FAIL bubble_resume_count got %0d want 8", instr_count); else checks_passed++;
    tick();
    tick();
    checks_total++; if (instr_out !== 32'hA000_0008) $display("[TB] FAIL bubble_next_ir got %h want %h", instr_out, 32'hA000_0008); else checks_passed++;
    checks_total++; if (instr_count !== 16'd9) $display("[TB] FAIL bubble_next_count got %0d want 9", instr_count); else checks_passed++;
  endtask

  task automatic test_redirect();
    redirect_en   = 1'b1;
    redirect_addr = 10'h3F0;
    #1;
    checks_total++; if (pm_en !== 1'b0) $display("[TB] FAIL redir_pm_en got %b want 0", pm_en); else checks_passed++;
    tick();
    checks_total++; if (instr_valid !== 1'b0) $display("[TB] FAIL redir_bubble1 got %b want 0", instr_valid); else checks_passed++;
    checks_total++; if (instr_out !== 32'h0) $display("[TB] FAIL redir_bubble1_ir got %h want 0", instr_out); else checks_passed++;
    checks_total++; if (pm_addr !== 10'h3F0) $display("[TB] FAIL redir_target_addr got %h want 3f0", pm_addr); else checks_passed++;
    redirect_en = 1'b0;
    tick();
    checks_total++; if (instr_valid !== 1'b0) $display("[TB] FAIL redir_bubble2 got %b want 0", instr_valid); else checks_passed++;
    tick();
    checks_total++; if (instr_out !== 32'hA000_03F0) $display("[TB] FAIL redir_target_ir got %h want %h", instr_out, 32'hA000_03F0); else checks_passed++;
    checks_total++; if (pc_out !== 10'h3F0) $display("[TB] FAIL redir_target_pc_out got %h want 3f0", pc_out); else checks_passed++;
    checks_total++; if (instr_count !== 16'd10) $display("[TB] FAIL redir_count got %0d want 10", instr_count); else checks_passed++;
  endtask

  task automatic test_redirect_during_stall();
    stall = 1'b1;
    tick();
    checks_total++; if (instr_out !== 32'hA000_03F0) $display("[TB] FAIL rstall_hold_ir got %h want %h", instr_out, 32'hA000_03F0); else checks_passed++;
    checks_total++; if (pm_addr !== 10'h3F2) $display("[TB] FAIL rstall_pc got %h want 3f2", pm_addr); else checks_passed++;
    redirect_en   = 1'b1;
    redirect_addr = 10'h3FF;
    tick();
    checks_total++; if (instr_valid !== 1'b0) $display("[TB] FAIL rstall_flush_valid got %b want 0", instr_valid); else checks_passed++;
    checks_total++; if (instr_out !== 32'h0) $display("[TB] FAIL rstall_flush_ir got %h want 0", instr_out); else checks_passed++;
    checks_total++; if (pm_addr !== 10'h3FF) $display("[TB] FAIL rstall_target got %h want 3ff", pm_addr); else checks_passed++;
    redirect_en = 1'b0;
    stall       = 1'b0;
    #1;
    checks_total++; if (pm_en !== 1'b1) $display("[TB] FAIL rstall_skid_cleared got %b want 1", pm_en); else checks_passed++;
    tick();
    checks_total++; if (pm_addr !== 10'h0) $display("[TB] FAIL wrap_addr got %h want 0", pm_addr); else checks_passed++;
    checks_total++; if (instr_valid !== 1'b0) $display("[TB] FAIL rstall_bubble2 got %b want 0", instr_valid); else checks_passed++;
    tick();
    checks_total++; if (instr_out !== 32'hA000_03FF) $display("[TB] FAIL rstall_target_ir got %h want %h", instr_out, 32'hA000_03FF); else checks_passed++;
    checks_total++; if (pc_out !== 10'h3FF) $display("[TB] FAIL rstall_target_pc_out got %h want 3ff", pc_out); else checks_passed++;
    checks_total++; if (instr_count !== 16'd11) $display("[TB] FAIL rstall_count got %0d want 11", instr_count); else checks_passed++;
    tick();
    checks_total++; if (instr_out !== 32'hA000_0000) $display("[TB] FAIL wrap_ir got %h want %h", instr_out, 32'hA000_0000); else checks_passed++;
    checks_total++; if (pc_out !== 10'h0) $display("[TB] FAIL wrap_pc_out got %h want 0", pc_out); else checks_passed++;
    checks_total++; if (instr_count !== 16'd12) $display("[TB] FAIL wrap_count got %0d want 12", instr_count); else checks_passed++;
  endtask

  task automatic test_count_saturation();
    force dut.count_q = 16'hFFFE;
    #1;
    release dut.count_q;
    tick();
    checks_total++; if (instr_count !== 16'hFFFF) $display("[TB] FAIL sat_reach got %h want ffff", instr_count); else checks_passed++;
    checks_total++; if (instr_out !== 32'hA000_0001) $display("[TB] FAIL sat_ir1 got %h want %h", instr_out, 32'hA000_0001); else checks_passed++;
    tick();
    checks_total++; if (instr_count !== 16'hFFFF) $display("[TB] FAIL sat_hold got %h want ffff", instr_count); else checks_passed++;
    checks_total++; if (instr_out !== 32'hA000_0002) $display("[TB] FAIL sat_ir2 got %h want %h", instr_out, 32'hA000_0002); else checks_passed++;
  endtask

  task automatic test_async_reset();
    stall = 1'b1;
    tick();
    #1;
    reset = 1'b1;
    #1;
    checks_total++; if (instr_out !== 32'h0) $display("[TB] FAIL areset_ir got %h want 0", instr_out); else checks_passed++;
    checks_total++; if (pc_out !== 10'h0) $display("[TB] FAIL areset_pc_out got %h want 0", pc_out); else checks_passed++;
    checks_total++; if (instr_valid !== 1'b0) $display("[TB] FAIL areset_valid got %b want 0", instr_valid); else checks_passed++;
    checks_total++; if (instr_count !== 16'h0) $display("[TB] FAIL areset_count got %h want 0", instr_count); else checks_passed++;
    checks_total++; if (op_dec !== 6'h0) $display("[TB] FAIL areset_op_dec got %h want 0", op_dec); else checks_passed++;
    checks_total++; if (pm_addr !== 10'h0) $display("[TB] FAIL areset_pm_addr got %h want 0", pm_addr); else checks_passed++;
    checks_total++; if (pm_en !== 1'b0) $display("[TB] FAIL areset_pm_en got %b want 0", pm_en); else checks_passed++;
    tick();
    reset = 1'b0;
    stall = 1'b0;
    #1;
    checks_total++; if (pm_en !== 1'b1) $display("[TB] FAIL restart_pm_en got %b want 1", pm_en); else checks_passed++;
    checks_total++; if (pm_addr !== 10'h0) $display("[TB] FAIL restart_addr0 got %h want 0", pm_addr); else checks_passed++;
    tick();
    checks_total++; if (pm_addr !== 10'h1) $display("[TB] FAIL restart_addr1 got %h want 1", pm_addr); else checks_passed++;
    tick();
    checks_total++; if (instr_out !== 32'hA000_0000) $display("[TB] FAIL restart_ir got %h want %h", instr_out, 32'hA000_0000); else checks_passed++;
    checks_total++; if (instr_valid !== 1'b1) $display("[TB] FAIL restart_valid got %b want 1", instr_valid); else checks_passed++;
    checks_total++; if (instr_count !== 16'd1) $display("[TB] FAIL restart_count got %0d want 1", instr_count); else checks_passed++;
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    reset         = 1'b1;
    stall         = 1'b0;
    stall_pm      = 1'b0;
    redirect_en   = 1'b0;
    redirect_addr = 10'h0;
    test_reset();
    test_stream();
    test_stall();
    test_bubble();
    test_redirect();
    test_redirect_during_stall();
    test_count_saturation();
    test_async_reset();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/instr_fetch_stage.md
Name: instr_fetch_stage

Overview:
- Fetch stage directly upstream of the stall control unit.
- Owns the PC and drives the program-memory address. Captures fetched words into the instruction register (IR) and presents op_dec = IR[31:26] to stall control.
- Consumes stall and stall_pm from stall control, plus redirect (jump/branch) from execute.
- A one-entry skid buffer keeps words that are already in flight from being lost while stalled.

Parameters:
- PC_W, 10, PC / program-memory word-address width.
- INSTR_W, 32, instruction width (op_dec is always IR[INSTR_W-1:INSTR_W-6]).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  from stall control; blocks new fetch issue and holds IR.
- stall_pm  input  1  from stall control; forces a NOP bubble into IR.
- redirect_en  input  1  jump/branch taken this cycle.
- redirect_addr  input  PC_W  target word address.
- pm_addr  output  PC_W  program-memory address (equals pc register).
- pm_en  output  1  fetch issue strobe.
- pm_data  input  INSTR_W  program-memory read data, valid the cycle after pm_en.
- instr_out  output  INSTR_W  IR contents.
- pc_out  output  PC_W  address of the instruction in IR.
- instr_valid  output  1  IR holds a real instruction (not a bubble).
- op_dec  output  6  IR[31:26] to stall control.
- instr_count  output  16  delivered-instruction counter, saturating.

Behaviour:
- Reset (async, immediate): pc=RESET_PC, IR=0, pc_out=0, instr_valid=0, pend=0, skid_valid=0, instr_count=0. Comb outputs: pm_en=0 and op_dec=0 while reset is high.
- pm_addr = pc.
- pm_en = ~reset & ~stall & ~skid_valid & ~redirect_en (combinational).
- Registered on posedge:
  - pend <= pm_en
  - pend_pc <= pc
- PC update priority: redirect_en -> redirect_addr; else pm_en -> pc+1 (wraps modulo 2^PC_W, no flag); else hold.
- Incoming word = pm_data when pend=1.
- IR update priority:
  1. redirect_en: IR<=0, instr_valid<=0, skid_valid<=0. Any pending word is discarded as wrong-path.
  2. stall_pm: IR<=0, instr_valid<=0. A pending word goes to skid (skid<=pm_data, skid_pc<=pend_pc, skid_valid<=1).
  3. stall: IR, pc_out and instr_valid hold. A pending word goes to skid as above.
  4. Otherwise, if skid_valid: IR<=skid, pc_out<=skid_pc, instr_valid<=1, skid_valid<=0.
  5. Otherwise, if pend: IR<=pm_data, pc_out<=pend_pc, instr_valid<=1.
  6. Otherwise: IR<=0, instr_valid<=0.
- Skid capacity is 1. Overflow is impossible because pm_en=0 while skid_valid=1, so at most one word is in flight.
- instr_count increments on every cycle where case 4 or 5 loads IR. It saturates at 16'hFFFF.
- Redirect penalty: redirect at cycle t -> target issued at t+1 -> target in IR after edge t+2 (2 bubbles).
- Redirect simultaneous with stall/stall_pm: redirect wins.
- Reset mid-operation: all state cleared asynchronously; the first fetch issues in the first cycle after reset deasserts.

Test Plan:
- Bench PM returns 32'hA000_0000|addr one cycle after pm_en.
- Reset release: reset high 2 cycles then low -> pm_addr 0,1,2,... each cycle; instr_out 32'hA000_0000 (pc_out 0, valid) after the 2nd edge; instr_count 1,2,3.
- Stall: stall=1 for 3 cycles with IR=addr 4 -> pm_en=0, pc frozen at 6, addr-5 word held in skid, IR stays 0xA0000004. On release, IR=0xA0000005 next edge and then 0xA0000006; no word lost or duplicated.
- Bubble: stall_pm=1 one cycle with stall=1 -> IR=0, instr_valid=0, op_dec=0, instr_count unchanged. Afterwards the sequence resumes in order.
- Redirect: redirect_en=1, redirect_addr=10'h3F0 at cycle t -> next 2 IR cycles are NOP/invalid, then 0xA00003F0 with pc_out 3F0. A redirect during stall behaves identically and clears skid.
- Wrap: redirect to 10'h3FF -> next pm_addr after 3FF is 000. Separately, force instr_count to 16'hFFFE -> it reaches FFFF and stays.
- Async reset asserted mid-stall with skid_valid=1 -> all outputs 0 immediately without a clock edge; fetch restarts from RESET_PC.
